hub75_rx: RTL and testbench

HUB75 panel-side receiver. Samples the pin outputs produced by the team's HUB75 driver FSM and its shift path (panel_clk, rgb, lat, blank, row_clk, row_data), and decodes them into three event streams:
- pixel writes
- line latches, tagged with row and plane
- per-row display-on durations

It sits on the loopback/verification board and in the panel emulator, one per HUB75 connector. It checks driver timing and frame content in-system.

---
 rtl/hub75_pkg.sv | 34 +++
 rtl/hub75_rx_if.sv | 51 +++++
 rtl/hub75_pin_sync.sv | 38 +++
 rtl/hub75_rx.sv | 176 +++++++++++++++++
 tb/tb_hub75_rx.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 panel-side receiver.
//   - default geometry (columns, rows, data pins, show-counter width)
//   - rx_state_t receiver state encoding
//   - bit positions of the rgb data pins and of the packed control-pin vector
package hub75_pkg;

   localparam int unsigned DEF_COLS   = 128;
   localparam int unsigned DEF_ROWS   = 32;
   localparam int unsigned DEF_RGB_W  = 6;
   localparam int unsigned DEF_SHOW_W = 16;

   typedef enum logic [1:0] {
      UNSYNC,
      IDLE,
      SHOW
   } rx_state_t;

   // rgb pin order: {b2, g2, r2, b1, g1, r1}
   localparam int unsigned RGB_R1 = 0;
   localparam int unsigned RGB_G1 = 1;
   localparam int unsigned RGB_B1 = 2;
   localparam int unsigned RGB_R2 = 3;
   localparam int unsigned RGB_G2 = 4;
   localparam int unsigned RGB_B2 = 5;

   // control pins packed into one synchronizer vector
   localparam int unsigned PIN_PCLK    = 0;
   localparam int unsigned PIN_LAT     = 1;
   localparam int unsigned PIN_BLANK   = 2;
   localparam int unsigned PIN_ROWCLK  = 3;
   localparam int unsigned PIN_ROWDATA = 4;
   localparam int unsigned CTRL_W      = 5;

endpackage

// File: rtl/hub75_rx_if.sv
// hub75_rx_if: HUB75 connector pins plus the decoded event streams.
//   master : drives the pins (driver / bench side), observes the events
//   slave  : receiver side, samples the pins, produces the events
//   pins   : panel_clk, rgb, lat, blank, row_clk, row_data
//   events : px_*, line_*, show_*, synced, col_err
interface hub75_rx_if
   import hub75_pkg::*;
#(
   parameter int unsigned COLS   = DEF_COLS,
   parameter int unsigned ROWS   = DEF_ROWS,
   parameter int unsigned RGB_W  = DEF_RGB_W,
   parameter int unsigned SHOW_W = DEF_SHOW_W
);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned ROW_W = $clog2(ROWS);

   logic               panel_clk;
   logic [RGB_W-1:0]   rgb;
   logic               lat;
   logic               blank;
   logic               row_clk;
   logic               row_data;

   logic               px_valid;
   logic [COL_W-1:0]   px_col;
   logic [RGB_W-1:0]   px_rgb;
   logic               line_valid;
   logic [COL_W:0]     line_len;
   logic [ROW_W-1:0]   line_row;
   logic [2:0]         line_plane;
   logic               show_valid;
   logic [SHOW_W-1:0]  show_len;
   logic [ROW_W-1:0]   show_row;
   logic               synced;
   logic               col_err;

   modport master (
      output panel_clk, rgb, lat, blank, row_clk, row_data,
      input  px_valid, px_col, px_rgb,
      input  line_valid, line_len, line_row, line_plane,
      input  show_valid, show_len, show_row, synced, col_err
   );

   modport slave (
      input  panel_clk, rgb, lat, blank, row_clk, row_data,
      output px_valid, px_col, px_rgb,
      output line_valid, line_len, line_row, line_plane,
      output show_valid, show_len, show_row, synced, col_err
   );

endinterface

// File: rtl/hub75_pin_sync.sv
// hub75_pin_sync: 2-FF synchronizer for asynchronous pins plus an edge
// register. rise/fall are combinational from the last synchronizer stage and
// the edge register, so a pin change becomes visible to logic after 2 clocks.
//   clk, rst_n : clock, async active-low reset (all stages clear to 0)
//   din        : raw pin inputs
//   sync       : synchronized level
//   rise, fall : one-cycle edge flags aligned with sync
module hub75_pin_sync #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);
   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] stage;
   logic [WIDTH-1:0] prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= '0;
         stage <= '0;
         prev  <= '0;
      end else begin
         meta  <= din;
         stage <= meta;
         prev  <= stage;
      end
   end

   assign sync = stage;
   assign rise = stage & ~prev;
   assign fall = ~stage & prev;

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side receiver. Decodes the driver's pin activity into
// pixel writes, line latches (tagged with row and plane) and per-row
// display-on durations.
//   sys_clk : block clock, pins are asynchronous to it
//   rst_n   : async assert, active-low; release synchronized internally
//   bus     : hub75_rx_if slave (pins in, registered event outputs)
module hub75_rx
   import hub75_pkg::*;
#(
   parameter int unsigned COLS   = DEF_COLS,
   parameter int unsigned ROWS   = DEF_ROWS,
   parameter int unsigned RGB_W  = DEF_RGB_W,
   parameter int unsigned SHOW_W = DEF_SHOW_W
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   hub75_rx_if.slave  bus
);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned ROW_W = $clog2(ROWS);
   localparam logic [COL_W:0]   COL_FULL = COLS[COL_W:0];
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

   logic [1:0] rst_pipe;
   logic       rst_int_n;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= '0;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_int_n = rst_pipe[1];

   logic [CTRL_W-1:0] ctrl_sync, ctrl_rise, ctrl_fall;
   logic [RGB_W-1:0]  rgb_sync, rgb_rise, rgb_fall;

   hub75_pin_sync #(.WIDTH(CTRL_W)) u_ctrl_sync (
      .clk   (sys_clk),
      .rst_n (rst_int_n),
      .din   ({bus.row_data, bus.row_clk, bus.blank, bus.lat, bus.panel_clk}),
      .sync  (ctrl_sync),
      .rise  (ctrl_rise),
      .fall  (ctrl_fall)
   );

   // Same depth as the control path, so rgb_sync is the data at the clock rise.
   hub75_pin_sync #(.WIDTH(RGB_W)) u_rgb_sync (
      .clk   (sys_clk),
      .rst_n (rst_int_n),
      .din   (bus.rgb),
      .sync  (rgb_sync),
      .rise  (rgb_rise),
      .fall  (rgb_fall)
   );

   logic unused_edges;
   assign unused_edges = ^{rgb_rise, rgb_fall, ctrl_rise[PIN_ROWDATA], ctrl_rise[PIN_BLANK],
                           ctrl_fall[PIN_PCLK], ctrl_fall[PIN_LAT], ctrl_fall[PIN_ROWCLK],
                           ctrl_fall[PIN_ROWDATA], ctrl_sync[PIN_PCLK], ctrl_sync[PIN_LAT],
                           ctrl_sync[PIN_ROWCLK]};

   logic pclk_rise, lat_rise, row_rise, blank_rise, blank_fall, blank_lvl, row_data_lvl;
   assign pclk_rise    = ctrl_rise[PIN_PCLK];
   assign lat_rise     = ctrl_rise[PIN_LAT];
   assign row_rise     = ctrl_rise[PIN_ROWCLK];
   assign blank_rise   = ctrl_sync[PIN_BLANK] & ~ctrl_fall[PIN_BLANK] & ctrl_rise[PIN_BLANK];
   assign blank_fall   = ctrl_fall[PIN_BLANK];
   assign blank_lvl    = ctrl_sync[PIN_BLANK];
   assign row_data_lvl = ctrl_sync[PIN_ROWDATA];

   logic [COL_W:0]    col_cnt, col_base;
   logic [ROW_W-1:0]  row_idx, row_nxt;
   logic [2:0]        plane_cnt, plane_base;
   logic [SHOW_W-1:0] show_cnt;
   logic              px_take;

   // Same-cycle events resolve as row_clk, then panel_clk, then lat: the
   // *_base values are the counters after the earlier events have applied.
   always_comb begin
      row_nxt    = row_idx;
      plane_base = plane_cnt;
      if (row_rise) begin
         plane_base = '0;
         if (row_data_lvl || row_idx == ROW_LAST) row_nxt = '0;
         else                                      row_nxt = row_idx + 1'b1;
      end
      px_take  = pclk_rise && (col_cnt != COL_FULL);
      col_base = px_take ? col_cnt + 1'b1 : col_cnt;
   end

   logic              px_valid, line_valid, show_valid, synced, col_err;
   logic [COL_W-1:0]  px_col;
   logic [RGB_W-1:0]  px_rgb;
   logic [COL_W:0]    line_len;
   logic [ROW_W-1:0]  line_row, show_row;
   logic [2:0]        line_plane;
   logic [SHOW_W-1:0] show_len;
   rx_state_t         state;

   always_ff @(posedge sys_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         col_cnt    <= '0;
         row_idx    <= '0;
         plane_cnt  <= '0;
         show_cnt   <= '0;
         px_valid   <= 1'b0;
         px_col     <= '0;
         px_rgb     <= '0;
         line_valid <= 1'b0;
         line_len   <= '0;
         line_row   <= '0;
         line_plane <= '0;
         synced     <= 1'b0;
         col_err    <= 1'b0;
      end else begin
         px_valid <= px_take;
         if (px_take) begin
            px_col <= col_cnt[COL_W-1:0];
            px_rgb <= rgb_sync;
         end
         if (pclk_rise && !px_take) col_err <= 1'b1;
         if (row_rise && row_data_lvl) synced <= 1'b1;
         row_idx    <= row_nxt;
         line_valid <= lat_rise;
         if (lat_rise) begin
            line_len   <= col_base;
            line_row   <= row_nxt;
            line_plane <= plane_base;
            col_cnt    <= '0;
            plane_cnt  <= plane_base + 3'd1;
         end else begin
            col_cnt    <= col_base;
            plane_cnt  <= plane_base;
         end
         // The fall cycle is itself the first low cycle, so it loads 1:
         // show_len then equals the number of cycles blank was low.
         if (blank_fall)                          show_cnt <= {{(SHOW_W-1){1'b0}}, 1'b1};
         else if (!blank_lvl && show_cnt != '1)   show_cnt <= show_cnt + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state      <= UNSYNC;
         show_valid <= 1'b0;
         show_len   <= '0;
         show_row   <= '0;
      end else begin
         show_valid <= 1'b0;
         case (state)
            UNSYNC: if (row_rise && row_data_lvl) state <= IDLE;
            IDLE:   if (blank_fall) state <= SHOW;
            SHOW:   if (blank_rise) begin
                       state      <= IDLE;
                       show_valid <= 1'b1;
                       show_len   <= show_cnt;
                       show_row   <= row_idx;
                    end
            default: state <= UNSYNC;
         endcase
      end
   end

   assign bus.px_valid   = px_valid;
   assign bus.px_col     = px_col;
   assign bus.px_rgb     = px_rgb;
   assign bus.line_valid = line_valid;
   assign bus.line_len   = line_len;
   assign bus.line_row   = line_row;
   assign bus.line_plane = line_plane;
   assign bus.show_valid = show_valid;
   assign bus.show_len   = show_len;
   assign bus.show_row   = show_row;
   assign bus.synced     = synced;
   assign bus.col_err    = col_err;

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: self-checking bench for hub75_rx. Pin stimulus is driven through
// the interface; expected events are queued as stimulus is applied and compared
// against events captured from the DUT.
module tb_hub75_rx;
   import hub75_pkg::*;

   localparam int unsigned COLS   = 128;
   localparam int unsigned ROWS   = 32;
   localparam int unsigned RGB_W  = 6;
   localparam int unsigned SHOW_W = 16;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b1;

   hub75_rx_if #(.COLS(COLS), .ROWS(ROWS), .RGB_W(RGB_W), .SHOW_W(SHOW_W)) bus ();

   hub75_rx #(.COLS(COLS), .ROWS(ROWS), .RGB_W(RGB_W), .SHOW_W(SHOW_W)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int vectors     = 0;
   int miscompares = 0;

   // px: {col[6:0], rgb[5:0]}  line: {len[7:0], row[4:0], plane[2:0]}  show: {len[15:0], row[4:0]}
   logic [12:0] exp_px[$],   obs_px[$];
   logic [15:0] exp_line[$], obs_line[$];
   logic [20:0] exp_show[$], obs_show[$];

   always @(negedge sys_clk) begin
      if (bus.px_valid)   obs_px.push_back({bus.px_col, bus.px_rgb});
      if (bus.line_valid) obs_line.push_back({bus.line_len, bus.line_row, bus.line_plane});
      if (bus.show_valid) obs_show.push_back({bus.show_len, bus.show_row});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic pclk_pulse(input logic [5:0] d);
      bus.rgb = d;
      tick(2);
      bus.panel_clk = 1'b1;
      tick(3);
      bus.panel_clk = 1'b0;
      tick(2);
   endtask

   task automatic lat_pulse();
      bus.lat = 1'b1;
      tick(3);
      bus.lat = 1'b0;
      tick(3);
   endtask

   task automatic row_pulse(input logic d);
      bus.row_data = d;
      tick(2);
      bus.row_clk = 1'b1;
      tick(3);
      bus.row_clk = 1'b0;
      tick(2);
   endtask

   task automatic blank_low(input int n);
      bus.blank = 1'b0;
      tick(n);
      bus.blank = 1'b1;
      tick(4);
   endtask

   task automatic test_reset();
      bus.panel_clk = 1'b0; bus.rgb = '0; bus.lat = 1'b0;
      bus.blank = 1'b0; bus.row_clk = 1'b0; bus.row_data = 1'b0;
      #2 rst_n = 1'b0;
      tick(4);
      vectors++;
      if ({bus.px_valid, bus.line_valid, bus.show_valid, bus.synced, bus.col_err,
           bus.px_col, bus.line_len, bus.show_len} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold: outputs=%h required 0",
                  {bus.px_valid, bus.line_valid, bus.show_valid, bus.synced, bus.col_err,
                   bus.px_col, bus.line_len, bus.show_len});
      end
      rst_n = 1'b1;
      tick(4);
      vectors++;
      if ({bus.synced, bus.col_err, bus.line_row, bus.show_row} !== '0) begin
         miscompares++;
         $display("FAIL reset_release: synced=%b col_err=%b required 0", bus.synced, bus.col_err);
      end
      bus.blank = 1'b1;
      tick(4);
      blank_low(10);
      tick(6);
      vectors++;
      if (obs_show.size() != 0) begin
         miscompares++;
         $display("FAIL show_unsync: %0d show events, required 0", obs_show.size());
      end
      row_pulse(1'b1);
      tick(6);
      vectors++;
      if (bus.synced !== 1'b1) begin
         miscompares++;
         $display("FAIL synced: got %b required 1", bus.synced);
      end
      vectors++;
      if (obs_px.size() + obs_line.size() + obs_show.size() != 0) begin
         miscompares++;
         $display("FAIL spurious_events: %0d events, required 0",
                  obs_px.size() + obs_line.size() + obs_show.size());
      end
      obs_px.delete(); obs_line.delete(); obs_show.delete();
   endtask

   task automatic test_full_line();
      row_pulse(1'b1);
      for (int c = 0; c < 128; c++) begin
         pclk_pulse(6'(c));
         exp_px.push_back({7'(c), 6'(c)});
      end
      lat_pulse();
      exp_line.push_back({8'd128, 5'd0, 3'd0});
      tick(6);
      vectors++;
      if (obs_px.size() != exp_px.size()) begin
         miscompares++;
         $display("FAIL full_px_count: got %0d required %0d", obs_px.size(), exp_px.size());
      end
      while (obs_px.size() > 0 && exp_px.size() > 0) begin
         logic [12:0] o, e;
         o = obs_px.pop_front(); e = exp_px.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL full_px: got col=%0d rgb=%h required col=%0d rgb=%h", o[12:6], o[5:0], e[12:6], e[5:0]);
         end
      end
      vectors++;
      if (obs_line.size() != 1 || obs_line[0] !== exp_line[0]) begin
         miscompares++;
         $display("FAIL full_line: got %0d events first=%h required 1 event %h",
                  obs_line.size(), (obs_line.size() > 0) ? obs_line[0] : 16'h0, exp_line[0]);
      end
      obs_px.delete(); exp_px.delete(); obs_line.delete(); exp_line.delete();
   endtask

   task automatic test_overflow();
      row_pulse(1'b1);
      for (int c = 0; c < 129; c++) begin
         pclk_pulse(6'(c) ^ 6'h2A);
         if (c < 128) exp_px.push_back({7'(c), 6'(c) ^ 6'h2A});
      end
      tick(4);
      vectors++;
      if (bus.col_err !== 1'b1) begin
         miscompares++;
         $display("FAIL col_err_set: got %b required 1", bus.col_err);
      end
      lat_pulse();
      exp_line.push_back({8'd128, 5'd0, 3'd0});
      lat_pulse();
      exp_line.push_back({8'd0, 5'd0, 3'd1});
      tick(6);
      vectors++;
      if (bus.col_err !== 1'b1) begin
         miscompares++;
         $display("FAIL col_err_sticky: got %b required 1", bus.col_err);
      end
      vectors++;
      if (obs_px.size() != 128) begin
         miscompares++;
         $display("FAIL ovf_px_count: got %0d required 128", obs_px.size());
      end
      while (obs_px.size() > 0 && exp_px.size() > 0) begin
         logic [12:0] o, e;
         o = obs_px.pop_front(); e = exp_px.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL ovf_px: got %h required %h", o, e);
         end
      end
      vectors++;
      if (obs_line.size() != exp_line.size()) begin
         miscompares++;
         $display("FAIL ovf_line_count: got %0d required %0d", obs_line.size(), exp_line.size());
      end
      while (obs_line.size() > 0 && exp_line.size() > 0) begin
         logic [15:0] o, e;
         o = obs_line.pop_front(); e = exp_line.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL ovf_line: got len=%0d row=%0d plane=%0d required len=%0d row=%0d plane=%0d",
                     o[15:8], o[7:3], o[2:0], e[15:8], e[7:3], e[2:0]);
         end
      end
      obs_px.delete(); exp_px.delete(); obs_line.delete(); exp_line.delete();
   endtask

   task automatic test_planes_rows();
      row_pulse(1'b1);
      for (int i = 0; i < 7; i++) begin
         lat_pulse();
         exp_line.push_back({8'd0, 5'd0, 3'(i)});
      end
      row_pulse(1'b0);
      lat_pulse();
      exp_line.push_back({8'd0, 5'd1, 3'd0});
      row_pulse(1'b1);
      for (int i = 0; i < 31; i++) row_pulse(1'b0);
      lat_pulse();
      exp_line.push_back({8'd0, 5'd31, 3'd0});
      row_pulse(1'b0);
      lat_pulse();
      exp_line.push_back({8'd0, 5'd0, 3'd0});
      tick(6);
      vectors++;
      if (obs_line.size() != exp_line.size()) begin
         miscompares++;
         $display("FAIL plane_line_count: got %0d required %0d", obs_line.size(), exp_line.size());
      end
      while (obs_line.size() > 0 && exp_line.size() > 0) begin
         logic [15:0] o, e;
         o = obs_line.pop_front(); e = exp_line.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL plane_line: got len=%0d row=%0d plane=%0d required len=%0d row=%0d plane=%0d",
                     o[15:8], o[7:3], o[2:0], e[15:8], e[7:3], e[2:0]);
         end
      end
      obs_line.delete(); exp_line.delete();
   endtask

   task automatic test_show();
      int lens[4] = '{16, 32, 2048, 70000};
      row_pulse(1'b1);
      row_pulse(1'b0);
      row_pulse(1'b0);
      for (int i = 0; i < 4; i++) begin
         blank_low(lens[i]);
         exp_show.push_back({(lens[i] > 65535) ? 16'hFFFF : 16'(lens[i]), 5'd2});
      end
      tick(6);
      vectors++;
      if (obs_show.size() != exp_show.size()) begin
         miscompares++;
         $display("FAIL show_count: got %0d required %0d", obs_show.size(), exp_show.size());
      end
      while (obs_show.size() > 0 && exp_show.size() > 0) begin
         logic [20:0] o, e;
         o = obs_show.pop_front(); e = exp_show.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL show: got len=%0d row=%0d required len=%0d row=%0d", o[20:5], o[4:0], e[20:5], e[4:0]);
         end
      end
      obs_show.delete(); exp_show.delete();
   endtask

   task automatic test_coincident();
      row_pulse(1'b1);
      for (int c = 0; c < 5; c++) begin
         pclk_pulse(6'(c + 9));
         exp_px.push_back({7'(c), 6'(c + 9)});
      end
      bus.rgb = 6'h3F;
      tick(2);
      bus.panel_clk = 1'b1; bus.lat = 1'b1;
      tick(3);
      bus.panel_clk = 1'b0; bus.lat = 1'b0;
      tick(3);
      exp_px.push_back({7'd5, 6'h3F});
      exp_line.push_back({8'd6, 5'd0, 3'd0});
      bus.row_data = 1'b0;
      tick(2);
      bus.row_clk = 1'b1; bus.lat = 1'b1;
      tick(3);
      bus.row_clk = 1'b0; bus.lat = 1'b0;
      tick(3);
      exp_line.push_back({8'd0, 5'd1, 3'd0});
      tick(6);
      vectors++;
      if (obs_px.size() != exp_px.size()) begin
         miscompares++;
         $display("FAIL coinc_px_count: got %0d required %0d", obs_px.size(), exp_px.size());
      end
      while (obs_px.size() > 0 && exp_px.size() > 0) begin
         logic [12:0] o, e;
         o = obs_px.pop_front(); e = exp_px.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL coinc_px: got %h required %h", o, e);
         end
      end
      vectors++;
      if (obs_line.size() != exp_line.size()) begin
         miscompares++;
         $display("FAIL coinc_line_count: got %0d required %0d", obs_line.size(), exp_line.size());
      end
      while (obs_line.size() > 0 && exp_line.size() > 0) begin
         logic [15:0] o, e;
         o = obs_line.pop_front(); e = exp_line.pop_front();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL coinc_line: got len=%0d row=%0d plane=%0d required len=%0d row=%0d plane=%0d",
                     o[15:8], o[7:3], o[2:0], e[15:8], e[7:3], e[2:0]);
         end
      end
      obs_px.delete(); exp_px.delete(); obs_line.delete(); exp_line.delete();
   endtask

   task automatic test_reset_midline();
      row_pulse(1'b1);
      for (int c = 0; c < 10; c++) pclk_pulse(6'(c + 20));
      tick(6);
      vectors++;
      if (obs_px.size() != 10 || bus.px_col !== 7'd9 || bus.px_rgb !== 6'd29) begin
         miscompares++;
         $display("FAIL midline_px: got %0d events last col=%0d rgb=%0d required 10 events col=9 rgb=29",
                  obs_px.size(), bus.px_col, bus.px_rgb);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.px_valid, bus.px_col, bus.px_rgb, bus.line_valid, bus.line_len, bus.line_row,
           bus.line_plane, bus.show_valid, bus.show_len, bus.show_row, bus.synced, bus.col_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_async: px_col=%0d show_len=%h synced=%b col_err=%b required all 0",
                  bus.px_col, bus.show_len, bus.synced, bus.col_err);
      end
      tick(3);
      rst_n = 1'b1;
      tick(10);
      vectors++;
      if (obs_line.size() != 0) begin
         miscompares++;
         $display("FAIL reset_no_line: got %0d line events required 0", obs_line.size());
      end
      lat_pulse();
      tick(6);
      vectors++;
      if (obs_line.size() != 1 || obs_line[0] !== {8'd0, 5'd0, 3'd0} || bus.synced !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_line: got %0d events first=%h synced=%b required 1 event 0000 synced 0",
                  obs_line.size(), (obs_line.size() > 0) ? obs_line[0] : 16'hFFFF, bus.synced);
      end
      obs_px.delete(); obs_line.delete(); obs_show.delete();
   endtask

   initial begin
      test_reset();
      test_full_line();
      test_overflow();
      test_planes_rows();
      test_show();
      test_coincident();
      test_reset_midline();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
